// File: rtl/dp_pkg.sv
// Shared constants and FSM encoding for the datapoint buffer.
package dp_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int FEAT_WIDTH = 16;
  localparam int MAX_FEAT   = 12;
  localparam int WORD_W     = FEAT_WIDTH * MAX_FEAT;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FULL,
    ST_READ,
    ST_DONE
  } state_t;
endpackage

// File: rtl/dp_buffer_if.sv
// Word-in / feature-out handshake bundle for dp_buffer.
interface dp_buffer_if #(
  parameter int FEAT_WIDTH = dp_pkg::FEAT_WIDTH,
  parameter int MAX_FEAT   = dp_pkg::MAX_FEAT,
  parameter int ADDR_WIDTH = dp_pkg::ADDR_WIDTH
);
  logic                                in_valid;
  logic                                in_ready;
  logic [MAX_FEAT-1:0][FEAT_WIDTH-1:0] in_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [FEAT_WIDTH-1:0]               out_data;
  logic [ADDR_WIDTH-1:0]               out_dp_idx;
  logic [3:0]                          out_feat_idx;
  logic                                out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_dp_idx, out_feat_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_dp_idx, out_feat_idx, out_last
  );
endinterface

// File: rtl/dp_mem.sv
// Datapoint storage: DEPTH words, one synchronous write port, one async read port.
module dp_mem #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = dp_pkg::WORD_W,
  parameter int AW     = 2
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dp_buffer.sv
// Datapoint buffer: loads n packed words, then replays them feature by feature.
// Optional DP_BUFFER_DROPCNT_EN adds a saturating drop_cnt of refused input words.
module dp_buffer #(
  parameter int ADDR_WIDTH = dp_pkg::ADDR_WIDTH,
  parameter int FEAT_WIDTH = dp_pkg::FEAT_WIDTH,
  parameter int MAX_FEAT   = dp_pkg::MAX_FEAT,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] num_dp,
  input  logic [3:0]            feat,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
`ifdef DP_BUFFER_DROPCNT_EN
  output logic [7:0]            drop_cnt,
`endif
  dp_buffer_if.slave            bus
);
  import dp_pkg::*;

  localparam int WW  = FEAT_WIDTH * MAX_FEAT;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                              state;
  logic                                cfg_vld;
  logic [ADDR_WIDTH-1:0]               n_m1, n_m1_cfg, wr_ptr, nxt_dp;
  logic [3:0]                          f_m1, f_m1_cfg, nxt_feat;
  logic                                wr_fire, rd_fire, rd_start, nxt_last;
  logic [WW-1:0]                       rword;
  logic [MAX_FEAT-1:0][FEAT_WIDTH-1:0] rfeat;

  // Out-of-range counts fall back to the full storage / full word.
  assign n_m1_cfg = (num_dp == '0 || 32'(num_dp) > DEPTH) ? ADDR_WIDTH'(DEPTH - 1)
                                                          : num_dp - ADDR_WIDTH'(1);
  assign f_m1_cfg = (32'(feat) > MAX_FEAT - 1) ? 4'(MAX_FEAT - 1) : feat;

  assign wr_fire  = bus.in_valid && bus.in_ready && (state == ST_LOAD);
  assign rd_fire  = bus.out_valid && bus.out_ready;
  assign rd_start = start && (state == ST_FULL || state == ST_DONE);

  // Next read position; the async read port looks it up so the output
  // registers load the new feature on the same edge that advances.
  always_comb begin
    nxt_dp   = bus.out_dp_idx;
    nxt_feat = bus.out_feat_idx;
    if (rd_start) begin
      nxt_dp   = '0;
      nxt_feat = '0;
    end else if (rd_fire) begin
      if (bus.out_feat_idx == f_m1) begin
        nxt_feat = '0;
        nxt_dp   = bus.out_dp_idx + ADDR_WIDTH'(1);
      end else begin
        nxt_feat = bus.out_feat_idx + 4'd1;
      end
    end
  end

  assign nxt_last = (nxt_dp == n_m1) && (nxt_feat == f_m1);
  assign rfeat    = rword;

  dp_mem #(.DEPTH(DEPTH), .WORD_W(WW), .AW(MAW)) u_mem (
    .CLK   (CLK),
    .we    (wr_fire),
    .waddr (wr_ptr[MAW-1:0]),
    .wdata (bus.in_data),
    .raddr (nxt_dp[MAW-1:0]),
    .rdata (rword)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state            <= ST_LOAD;
      cfg_vld          <= 1'b0;
      n_m1             <= '0;
      f_m1             <= '0;
      wr_ptr           <= '0;
      bus.in_ready     <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_dp_idx   <= '0;
      bus.out_feat_idx <= '0;
      bus.out_last     <= 1'b0;
      busy             <= 1'b1;
      done             <= 1'b0;
    end else begin
      // Dataset shape is captured once per reset.
      if (!cfg_vld) begin
        cfg_vld <= 1'b1;
        n_m1    <= n_m1_cfg;
        f_m1    <= f_m1_cfg;
      end

      case (state)
        ST_LOAD: begin
          bus.in_ready <= 1'b1;
          if (wr_fire) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (wr_ptr == n_m1) begin
              state        <= ST_FULL;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
            end
          end
        end
        ST_FULL, ST_DONE: begin
          if (start) begin
            state         <= ST_READ;
            bus.out_valid <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
          end
        end
        ST_READ: begin
          if (rd_fire && bus.out_last) begin
            state         <= ST_DONE;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase

      if (rd_start || (rd_fire && !bus.out_last)) begin
        bus.out_data     <= rfeat[nxt_feat];
        bus.out_dp_idx   <= nxt_dp;
        bus.out_feat_idx <= nxt_feat;
        bus.out_last     <= nxt_last;
      end
    end
  end

`ifdef DP_BUFFER_DROPCNT_EN
  always_ff @(posedge CLK) begin
    if (!RST)
      drop_cnt <= '0;
    else if (bus.in_valid && !bus.in_ready && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_dp_buffer.sv
// Directed bench for dp_buffer: load, readout with stalls, replay, clamping, reset abort.
`timescale 1ns/1ps
module tb_dp_buffer;
  localparam int AW = 12;
  localparam int FW = 16;
  localparam int MF = 12;
  localparam int DP = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] num_dp;
  logic [3:0]    feat;
  logic          start;
  logic          busy;
  logic          done;
`ifdef DP_BUFFER_DROPCNT_EN
  logic [7:0]    drop_cnt;
`endif

  dp_buffer_if #(.FEAT_WIDTH(FW), .MAX_FEAT(MF), .ADDR_WIDTH(AW)) bus ();

  dp_buffer #(.ADDR_WIDTH(AW), .FEAT_WIDTH(FW), .MAX_FEAT(MF), .DEPTH(DP)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .num_dp   (num_dp),
    .feat     (feat),
    .start    (start),
    .busy     (busy),
    .done     (done),
`ifdef DP_BUFFER_DROPCNT_EN
    .drop_cnt (drop_cnt),
`endif
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic [11:0] dp;
    logic [3:0]  ft;
    logic        last;
    int          stall;
    logic        st;
  } vec_t;

  vec_t tbl [12];
  int   checks = 0;
  int   errors = 0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [MF*FW-1:0] mk_word(input logic [15:0] base, input int d);
    logic [MF*FW-1:0] w;
    for (int k = 0; k < MF; k++) w[16*k +: 16] = base + 16'(k + 16*d);
    return w;
  endfunction

  task automatic do_reset(input logic [AW-1:0] n, input logic [3:0] f);
    RST = 1'b0; num_dp = n; feat = f; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) tick;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready, 0);
    chk("rst_done",      done, 0);
    chk("rst_out_last",  bus.out_last, 0);
    chk("rst_out_data",  bus.out_data, 0);
    RST = 1'b1;
    tick;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_busy",     busy, 1);
  endtask

  task automatic load(input logic [15:0] base, input int ndp);
    for (int d = 0; d < ndp; d++) begin
      chk("load_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = mk_word(base, d);
      tick;
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_busy",     busy, 0);
    chk("full_done",     done, 0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic run_table;
    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < tbl[i].stall; s++) begin
        bus.out_ready = 1'b0;
        tick;
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_data",  bus.out_data, tbl[i].data);
        chk("bp_dp",    bus.out_dp_idx, tbl[i].dp);
        chk("bp_ft",    bus.out_feat_idx, tbl[i].ft);
      end
      bus.out_ready = 1'b1;
      start = tbl[i].st;
      chk("tb_valid", bus.out_valid, 1);
      chk("tb_data",  bus.out_data, tbl[i].data);
      chk("tb_dp",    bus.out_dp_idx, tbl[i].dp);
      chk("tb_ft",    bus.out_feat_idx, tbl[i].ft);
      chk("tb_last",  bus.out_last, tbl[i].last);
      chk("tb_busy",  busy, 1);
      tick;
      start = 1'b0;
    end
    chk("end_valid", bus.out_valid, 0);
    chk("end_done",  done, 1);
    chk("end_busy",  busy, 0);
  endtask

  task automatic run_seq(input logic [15:0] base, input int ndp, input int nf);
    for (int i = 0; i < ndp*nf; i++) begin
      chk("seq_valid", bus.out_valid, 1);
      chk("seq_data",  bus.out_data, base + 16'(i % nf + 16*(i / nf)));
      chk("seq_dp",    bus.out_dp_idx, i / nf);
      chk("seq_ft",    bus.out_feat_idx, i % nf);
      chk("seq_last",  bus.out_last, (i == ndp*nf - 1) ? 1 : 0);
      tick;
    end
    chk("seq_end_valid", bus.out_valid, 0);
    chk("seq_end_done",  done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{16'h0A00, 12'd0, 4'd0, 1'b0, 0, 1'b0};
    tbl[1]  = '{16'h0A01, 12'd0, 4'd1, 1'b0, 0, 1'b0};
    tbl[2]  = '{16'h0A02, 12'd0, 4'd2, 1'b0, 0, 1'b0};
    tbl[3]  = '{16'h0A10, 12'd1, 4'd0, 1'b0, 0, 1'b0};
    tbl[4]  = '{16'h0A11, 12'd1, 4'd1, 1'b0, 0, 1'b1};
    tbl[5]  = '{16'h0A12, 12'd1, 4'd2, 1'b0, 3, 1'b0};
    tbl[6]  = '{16'h0A20, 12'd2, 4'd0, 1'b0, 0, 1'b0};
    tbl[7]  = '{16'h0A21, 12'd2, 4'd1, 1'b0, 0, 1'b0};
    tbl[8]  = '{16'h0A22, 12'd2, 4'd2, 1'b0, 0, 1'b0};
    tbl[9]  = '{16'h0A30, 12'd3, 4'd0, 1'b0, 0, 1'b0};
    tbl[10] = '{16'h0A31, 12'd3, 4'd1, 1'b0, 0, 1'b0};
    tbl[11] = '{16'h0A32, 12'd3, 4'd2, 1'b1, 0, 1'b0};

    // Load 4 x 3 features; config changes after release must be ignored.
    do_reset(12'd4, 4'd2);
    num_dp = 12'd1;
    feat   = 4'd0;
    pulse_start;
    chk("load_start_ignored", bus.out_valid, 0);
    chk("load_still_ready",   bus.in_ready, 1);
    load(16'h0A00, 4);
    pulse_start;
    run_table;

    // Replay from DONE.
    pulse_start;
    run_table;

    // Clamping: num_dp=0 -> 4 datapoints, feat=15 -> 12 features.
    do_reset(12'd0, 4'd15);
    load(16'h0A00, 4);
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    repeat (3) tick;
    bus.in_valid = 1'b0;
    chk("drop_in_ready", bus.in_ready, 0);
`ifdef DP_BUFFER_DROPCNT_EN
    chk("drop_cnt", drop_cnt, 3);
`endif
    pulse_start;
    run_seq(16'h0A00, 4, 12);

    // Reset abort at beat 7, then reload new data from entry 0.
    do_reset(12'd4, 4'd2);
    load(16'h0A00, 4);
    pulse_start;
    repeat (7) tick;
    chk("abort_beat_data", bus.out_data, 16'h0A21);
    chk("abort_beat_dp",   bus.out_dp_idx, 2);
    RST = 1'b0;
    tick;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready",  bus.in_ready, 0);
    chk("abort_done",      done, 0);
    do_reset(12'd4, 4'd2);
    chk("abort_wr_ptr", dut.wr_ptr, 0);
    load(16'h5000, 4);
    pulse_start;
    run_seq(16'h5000, 4, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
